// File: rtl/dice_game_ctrl.sv
// Multi-player dice game controller: start, roll, choose and turn control in one FSM.
// Optional build macro BUST_RESET_EN: a bust clears the current player's score.
module dice_game_ctrl #(
    parameter int PLAYERS   = 2,
    parameter int SIDES     = 6,
    parameter int TARGET    = 10,
    parameter int MAX_TURNS = 9,
    parameter int SCORE_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       roll_btn,
    input  logic                       choose_btn,
    input  logic                       choice,
    output logic [3:0]                 num,
    output logic [SCORE_W-1:0]         score,
    output logic [PLAYERS*SCORE_W-1:0] scores,
    output logic [2:0]                 player,
    output logic [3:0]                 turns,
    output logic [2:0]                 state,
    output logic                       won,
    output logic [2:0]                 winner,
    output logic                       game_over
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROLL   = 3'd1,
        CHOOSE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               roll_q, roll_d;
    logic               choose_q, choose_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         num_q, num_d;
    logic [SCORE_W-1:0] scores_q [PLAYERS];
    logic [SCORE_W-1:0] scores_d [PLAYERS];
    logic [2:0]         player_q, player_d;
    logic [3:0]         turns_q, turns_d;
    logic               won_q, won_d;
    logic [2:0]         winner_q, winner_d;

    logic               roll_fall;
    logic               choose_rise;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W:0]   sum;
    logic               last_player;
    logic [3:0]         turns_inc;

    always_comb begin
        roll_fall   = ~roll_btn & roll_q;
        choose_rise = choose_btn & ~choose_q;
        last_player = (player_q == 3'(PLAYERS - 1));
        turns_inc   = turns_q + 4'd1;

        cur_score = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (player_q == 3'(p)) cur_score = scores_q[p];
        end
        // One extra bit so an overshoot past TARGET is visible as a bust.
        sum = (SCORE_W + 1)'(cur_score) + (SCORE_W + 1)'(num_q);

        state_d  = state_q;
        roll_d   = roll_btn;
        choose_d = choose_btn;
        cnt_d    = cnt_q;
        num_d    = num_q;
        scores_d = scores_q;
        player_d = player_q;
        turns_d  = turns_q;
        won_d    = won_q;
        winner_d = winner_q;

        case (state_q)
            IDLE: begin
                if (roll_fall) begin
                    state_d = ROLL;
                    cnt_d   = 4'd1;
                end
            end
            ROLL: begin
                if (roll_btn) begin
                    cnt_d = (cnt_q == 4'(SIDES)) ? 4'd1 : cnt_q + 4'd1;
                end else if (roll_fall) begin
                    num_d   = cnt_q;
                    state_d = CHOOSE;
                end
            end
            CHOOSE: begin
                if (choose_rise) begin
                    if (choice) begin
                        for (int unsigned p = 0; p < PLAYERS; p++) begin
                            if (player_q == 3'(p)) begin
                                if (sum <= (SCORE_W + 1)'(TARGET)) begin
                                    scores_d[p] = sum[SCORE_W-1:0];
                                end else begin
`ifdef BUST_RESET_EN
                                    scores_d[p] = '0;
`else
                                    scores_d[p] = scores_q[p];
`endif
                                end
                            end
                        end
                    end
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cur_score == SCORE_W'(TARGET)) begin
                    won_d    = 1'b1;
                    winner_d = player_q;
                    state_d  = DONE;
                end else if (last_player) begin
                    player_d = '0;
                    turns_d  = turns_inc;
                    if (turns_inc == 4'(MAX_TURNS)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ROLL;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    player_d = player_q + 3'd1;
                    state_d  = ROLL;
                    cnt_d    = 4'd1;
                end
            end
            DONE: begin
                if (roll_fall) begin
                    for (int unsigned p = 0; p < PLAYERS; p++) scores_d[p] = '0;
                    num_d    = '0;
                    turns_d  = '0;
                    player_d = '0;
                    won_d    = 1'b0;
                    winner_d = '0;
                    state_d  = ROLL;
                    cnt_d    = 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            roll_q   <= 1'b0;
            choose_q <= 1'b0;
            cnt_q    <= 4'd1;
            num_q    <= '0;
            for (int unsigned p = 0; p < PLAYERS; p++) scores_q[p] <= '0;
            player_q <= '0;
            turns_q  <= '0;
            won_q    <= 1'b0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            roll_q   <= roll_d;
            choose_q <= choose_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            for (int unsigned p = 0; p < PLAYERS; p++) scores_q[p] <= scores_d[p];
            player_q <= player_d;
            turns_q  <= turns_d;
            won_q    <= won_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        scores = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            scores[p*SCORE_W +: SCORE_W] = scores_q[p];
        end
    end

    assign num       = num_q;
    assign score     = cur_score;
    assign player    = player_q;
    assign turns     = turns_q;
    assign state     = state_q;
    assign won       = won_q;
    assign winner    = winner_q;
    assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Directed bench for dice_game_ctrl: two players, target 10, three-round limit.
module tb_dice_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       roll_btn = 1'b0;
    logic       choose_btn = 1'b0;
    logic       choice = 1'b0;
    logic [3:0] num;
    logic [3:0] score;
    logic [7:0] scores;
    logic [2:0] player;
    logic [3:0] turns;
    logic [2:0] state;
    logic       won;
    logic [2:0] winner;
    logic       game_over;

    int checks = 0;
    int failures = 0;

    dice_game_ctrl #(
        .PLAYERS(2), .SIDES(6), .TARGET(10), .MAX_TURNS(3), .SCORE_W(4)
    ) dut (
        .clk(clk), .rst(rst), .roll_btn(roll_btn), .choose_btn(choose_btn),
        .choice(choice), .num(num), .score(score), .scores(scores),
        .player(player), .turns(turns), .state(state), .won(won),
        .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold roll for n cycles then release; the die shows (n mod 6)+1.
    task automatic do_roll(input int n);
        roll_btn = 1'b1;
        repeat (n) tick();
        roll_btn = 1'b0;
        tick();
    endtask

    // Choose press: leaves the bench in CHECK (score already updated).
    task automatic press_choose(input logic c);
        choice = c;
        choose_btn = 1'b1;
        tick();
        choose_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (num !== 4'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num); end
        checks++; if (scores !== 8'h00) begin failures++; $display("FAIL reset_scores got=%h exp=00", scores); end
        checks++; if (player !== 3'd0 || turns !== 4'd0) begin failures++; $display("FAIL reset_player_turns got=%0d/%0d exp=0/0", player, turns); end
        checks++; if (won !== 1'b0 || winner !== 3'd0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%0d/%b exp=0/0/0", won, winner, game_over); end
    endtask

    task automatic test_roll();
        roll_btn = 1'b1; tick();
        roll_btn = 1'b0; tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL idle_to_roll got=%0d exp=1", state); end
        choose_btn = 1'b1; tick();
        choose_btn = 1'b0; tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL choose_ignored_in_roll got=%0d exp=1", state); end
        do_roll(8);
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL roll_to_choose got=%0d exp=2", state); end
        checks++; if (num !== 4'd3) begin failures++; $display("FAIL roll_wrap_num got=%0d exp=3", num); end
        roll_btn = 1'b1; tick();
        roll_btn = 1'b0; tick();
        checks++; if (state !== 3'd2 || num !== 4'd3) begin failures++; $display("FAIL roll_ignored_in_choose got=%0d/%0d exp=2/3", state, num); end
    endtask

    task automatic test_choose_add();
        press_choose(1'b1);
        checks++; if (scores !== 8'h03 || score !== 4'd3) begin failures++; $display("FAIL add_latency got=%h/%0d exp=03/3", scores, score); end
        checks++; if (state !== 3'd3 || player !== 3'd0) begin failures++; $display("FAIL check_state got=%0d/%0d exp=3/0", state, player); end
        tick();
        checks++; if (state !== 3'd1 || player !== 3'd1 || turns !== 4'd0) begin failures++; $display("FAIL next_player got=%0d/%0d/%0d exp=1/1/0", state, player, turns); end
        do_roll(3);
        checks++; if (num !== 4'd4) begin failures++; $display("FAIL p1_roll got=%0d exp=4", num); end
        press_choose(1'b1); tick();
        checks++; if (scores !== 8'h43 || player !== 3'd0 || turns !== 4'd1) begin failures++; $display("FAIL wrap_round got=%h/%0d/%0d exp=43/0/1", scores, player, turns); end
    endtask

    task automatic test_skip();
        do_roll(4);
        press_choose(1'b1); tick();
        checks++; if (scores !== 8'h48) begin failures++; $display("FAIL p0_to_8 got=%h exp=48", scores); end
        do_roll(5);
        checks++; if (num !== 4'd6) begin failures++; $display("FAIL p1_roll6 got=%0d exp=6", num); end
        press_choose(1'b0); tick();
        checks++; if (scores !== 8'h48 || player !== 3'd0 || turns !== 4'd2) begin failures++; $display("FAIL skip got=%h/%0d/%0d exp=48/0/2", scores, player, turns); end
    endtask

    task automatic test_bust();
        logic [7:0] exp_scores;
`ifdef BUST_RESET_EN
        exp_scores = 8'h40;
`else
        exp_scores = 8'h48;
`endif
        do_roll(2);
        press_choose(1'b1);
        checks++; if (scores !== exp_scores) begin failures++; $display("FAIL bust got=%h exp=%h", scores, exp_scores); end
        tick();
        checks++; if (won !== 1'b0 || state !== 3'd1 || player !== 3'd1) begin failures++; $display("FAIL bust_no_win got=%b/%0d/%0d exp=0/1/1", won, state, player); end
    endtask

    task automatic test_win();
        do_roll(5);
        press_choose(1'b1); tick();
        checks++; if (won !== 1'b1 || winner !== 3'd1) begin failures++; $display("FAIL win got=%b/%0d exp=1/1", won, winner); end
        checks++; if (state !== 3'd4 || game_over !== 1'b1 || turns !== 4'd2) begin failures++; $display("FAIL win_done got=%0d/%b/%0d exp=4/1/2", state, game_over, turns); end
        press_choose(1'b1); tick();
        checks++; if (state !== 3'd4 || scores[7:4] !== 4'd10 || won !== 1'b1) begin failures++; $display("FAIL done_hold got=%0d/%h/%b exp=4/a/1", state, scores[7:4], won); end
        roll_btn = 1'b1; tick();
        roll_btn = 1'b0; tick();
        checks++; if (state !== 3'd1 || scores !== 8'h00 || num !== 4'd0) begin failures++; $display("FAIL restart got=%0d/%h/%0d exp=1/00/0", state, scores, num); end
        checks++; if (won !== 1'b0 || winner !== 3'd0 || turns !== 4'd0 || player !== 3'd0 || game_over !== 1'b0) begin failures++; $display("FAIL restart_flags got=%b/%0d/%0d/%0d/%b exp=0/0/0/0/0", won, winner, turns, player, game_over); end
    endtask

    task automatic test_turn_limit();
        for (int i = 0; i < 6; i++) begin
            do_roll(1);
            press_choose(1'b0); tick();
            if (i == 4) begin
                checks++; if (state !== 3'd1 || turns !== 4'd2) begin failures++; $display("FAIL before_limit got=%0d/%0d exp=1/2", state, turns); end
            end
        end
        checks++; if (game_over !== 1'b1 || won !== 1'b0 || state !== 3'd4) begin failures++; $display("FAIL limit_done got=%b/%b/%0d exp=1/0/4", game_over, won, state); end
        checks++; if (turns !== 4'd3 || player !== 3'd0 || scores !== 8'h00) begin failures++; $display("FAIL limit_counts got=%0d/%0d/%h exp=3/0/00", turns, player, scores); end
    endtask

    task automatic test_rst_mid();
        roll_btn = 1'b1; tick();
        roll_btn = 1'b0; tick();
        do_roll(2);
        press_choose(1'b1); tick();
        do_roll(1);
        checks++; if (state !== 3'd2 || scores !== 8'h03 || player !== 3'd1) begin failures++; $display("FAIL pre_rst got=%0d/%h/%0d exp=2/03/1", state, scores, player); end
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if (state !== 3'd0 || scores !== 8'h00 || num !== 4'd0 || player !== 3'd0) begin failures++; $display("FAIL mid_rst got=%0d/%h/%0d/%0d exp=0/00/0/0", state, scores, num, player); end
        checks++; if (turns !== 4'd0 || won !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%0d/%b/%b exp=0/0/0", turns, won, game_over); end
    endtask

    initial begin
        test_reset();
        test_roll();
        test_choose_add();
        test_skip();
        test_bust();
        test_win();
        test_turn_limit();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
Name: dice_game_ctrl

Overview:
Parametrised multi-player successor to the single-player dice game controller. It merges start, roll, choose and turn control into one FSM. It supports PLAYERS players, a SIDES-sided die, a configurable target score and a turn limit, and it reports the winner. It sits between the debounced KEY-derived buttons and the Digit/LEDR display logic in the top level.

Parameters:
PLAYERS, 2, number of players (1..8); turn order wraps from PLAYERS-1 back to 0
SIDES, 6, die faces; rolled values are 1..SIDES (2..15)
TARGET, 10, exact score needed to win (must be < 2**SCORE_W)
MAX_TURNS, 9, rounds before the game ends with no winner (1..15)
SCORE_W, 4, width of each player's score register

Ports:
clk  in  1  system clock (MAX10_CLK1_50 at top)
rst  in  1  synchronous, active-high reset
roll_btn  in  1  roll button, active-high, already inverted from KEY
choose_btn  in  1  confirm button, active-high
choice  in  1  1 = add the rolled value to the current player's score, 0 = skip
num  out  4  last rolled value; 0 = no roll yet
score  out  SCORE_W  score of the current player
scores  out  PLAYERS*SCORE_W  all scores; player p occupies bits [p*SCORE_W +: SCORE_W]
player  out  3  index of the current player
turns  out  4  completed rounds
state  out  3  FSM state encoding
won  out  1  high in DONE when a player hit TARGET
winner  out  3  index of the winning player; valid only while won=1
game_over  out  1  high in DONE

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, num=0, all scores=0, player=0, turns=0, won=0, winner=0, game_over=0, roll counter=1, button history registers=0.
- rst has priority over every other input in any state.
- Button history: roll_q and choose_q are registered copies of the buttons.
  - rise = btn & ~btn_q; fall = ~btn & btn_q.
  - Edges are acted on at the same clock edge on which they are detected.
- State encoding: IDLE=0, ROLL=1, CHOOSE=2, CHECK=3, DONE=4.
- IDLE: on fall(roll_btn), go to ROLL and set the roll counter to 1.
- ROLL:
  - Each cycle with roll_btn=1, the counter advances (counter==SIDES ? 1 : counter+1).
  - On fall(roll_btn), num <= counter and go to CHOOSE.
  - choose_btn is ignored.
- CHOOSE: on rise(choose_btn), compute s = score[player] + num in SCORE_W+1 bits.
  - choice=0: score unchanged.
  - choice=1 and s <= TARGET: score[player] <= s.
  - choice=1 and s > TARGET (bust): score unchanged.
  - In every case go to CHECK. roll_btn is ignored.
- CHECK (exactly one cycle):
  - If score[player]==TARGET: won=1, winner=player, go to DONE.
  - Otherwise, if player==PLAYERS-1: player=0 and turns=turns+1. When the new turns equals MAX_TURNS, go to DONE with won=0; otherwise go to ROLL.
  - Otherwise (player < PLAYERS-1): player=player+1, go to ROLL.
  - The roll counter is set to 1 on every entry to ROLL.
- DONE:
  - game_over=1. All outputs hold.
  - fall(roll_btn) clears scores, num, turns, player, won and winner, then goes to ROLL. This is a new game without reset.
- Latency: choose press to updated score is 1 cycle; choose press to next player's ROLL state is 2 cycles.
- A button held across a state change produces no edge in the new state. Only a fresh edge counts.
- Outputs score and scores are registered. No combinational path exists from button inputs to outputs.

Optional Feature:
BUST_RESET_EN
- Defined: a bust (choice=1, s > TARGET) clears score[player] to 0.
- Not defined: a bust leaves the score unchanged.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then release roll in IDLE, then hold roll 8 cycles and release -> state ROLL then CHOOSE; num=3 ((1+8) wraps past 6).
- PLAYERS=2: player 0 rolls 4, choice=1, press choose -> scores[3:0]=4; player=1 two cycles later; turns=0.
- Player 1 finishes with choice=0 -> player=0, turns=1, player 1 score unchanged.
- Player at 8 rolls 3 with choice=1 -> default build: score stays 8; with BUST_RESET_EN: score=0. Neither build sets won.
- Player at 6 rolls 4 with choice=1 -> won=1, winner=that index, game_over=1, state=4. Further choose presses have no effect; roll release restarts with all scores=0.
- MAX_TURNS=3 with every choice=0 -> after 6 choose presses game_over=1, won=0, turns=3. rst asserted mid-CHOOSE -> all outputs return to reset values on the next clk edge.
